// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
package tdm_pkg;

  typedef enum logic {HUNT, COLLECT} state_t;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 8;

  // Channel counter width; NCH >= 2 keeps this at least one bit.
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_demux_if.sv
// Sample stream in, published frame and status pulses out.
interface tdm_demux_if #(
  parameter int NCH = 4,
  parameter int W   = 8
);
  logic               in_valid;
  logic               in_sof;
  logic [W-1:0]       in_data;
  logic [NCH*W-1:0]   out_data;
  logic               out_valid;
  logic [NCH-1:0]     ch_strobe;
  logic               frame_err;

  modport master (output in_valid, in_sof, in_data,
                  input  out_data, out_valid, ch_strobe, frame_err);
  modport slave  (input  in_valid, in_sof, in_data,
                  output out_data, out_valid, ch_strobe, frame_err);
endinterface

// File: rtl/demux_onehot.sv
// Combinational 1-to-N decoder: one-hot of sel when en, else zero.
module demux_onehot #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [SW-1:0] sel,
  input  logic          en,
  output logic [N-1:0]  onehot
);
  always_comb begin
    onehot = '0;
    for (int k = 0; k < N; k++)
      onehot[k] = en && (sel == SW'(k));
  end
endmodule

// File: rtl/tdm_demux.sv
// TDM demux: gathers NCH samples into shadow slots, publishes whole frames
// atomically, flags framing errors and resyncs on the next SOF.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux_if.slave    bus
);
  localparam int CW = cnt_w(NCH);
  localparam logic [CW-1:0] LAST = CW'(NCH-1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          ch_cnt, cnt_nxt, wr_sel;
  logic                   wr_en, err, publish;
  logic [NCH-1:0]         wr_oh, strobe_q;
  logic [NCH-1:0][W-1:0]  shadow, frame_q, frame_nxt;
  logic                   out_valid_q, err_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = ch_cnt;
    wr_en     = 1'b0;
    wr_sel    = '0;
    err       = 1'b0;
    if (bus.in_valid) begin
      unique case (state)
        HUNT: if (bus.in_sof) begin
          wr_en     = 1'b1;
          cnt_nxt   = ONE;
          state_nxt = COLLECT;
        end
        COLLECT: begin
          if (ch_cnt == '0) begin
            if (bus.in_sof) begin
              wr_en   = 1'b1;
              cnt_nxt = ONE;
            end else begin
              err       = 1'b1;
              cnt_nxt   = '0;
              state_nxt = HUNT;
            end
          end else if (!bus.in_sof) begin
            wr_en   = 1'b1;
            wr_sel  = ch_cnt;
            cnt_nxt = (ch_cnt == LAST) ? '0 : ch_cnt + ONE;
          end else begin
            // Early SOF: partial frame is abandoned, this sample restarts slot 0.
            err     = 1'b1;
            wr_en   = 1'b1;
            cnt_nxt = ONE;
          end
        end
        default: ;
      endcase
    end
  end

  demux_onehot #(.N(NCH), .SW(CW)) u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (wr_oh)
  );

  assign publish = wr_oh[NCH-1];

  // Last slot bypasses the shadow so publication costs only one cycle.
  always_comb begin
    frame_nxt         = shadow;
    frame_nxt[NCH-1]  = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      ch_cnt      <= '0;
      shadow      <= '0;
      frame_q     <= '0;
      out_valid_q <= 1'b0;
      strobe_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      ch_cnt      <= cnt_nxt;
      for (int k = 0; k < NCH; k++)
        if (wr_oh[k]) shadow[k] <= bus.in_data;
      if (publish) frame_q <= frame_nxt;
      out_valid_q <= publish;
      strobe_q    <= wr_oh;
      err_q       <= err;
    end
  end

  assign bus.out_data  = frame_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ch_strobe = strobe_q;
  assign bus.frame_err = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux (NCH=4, W=8): expected strobes, errors and
// frames are queued with their due cycle when driven, checked when they appear.
module tb_tdm_demux;
  import tdm_pkg::*;
  localparam int NCH = NCH_DEF;
  localparam int W   = W_DEF;

  typedef struct { int cyc; logic [63:0] val; } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   last_ov = -100, prev_ov = -100;

  exp_t sq[$], eq[$], fq[$];

  // Reference state
  bit         m_coll;
  int         m_cnt;
  logic [7:0] m_sh [NCH];

  tdm_demux_if #(.NCH(NCH), .W(W)) bus ();

  tdm_demux #(.NCH(NCH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.ch_strobe != '0) begin
      if (sq.size() == 0) chk("strobe_unexp", 64'(bus.ch_strobe), 64'd0);
      else begin
        e = sq.pop_front();
        chk("strobe_cyc", 64'(cyc), 64'(e.cyc));
        chk("strobe", 64'(bus.ch_strobe), e.val);
      end
    end else if (sq.size() != 0 && sq[0].cyc <= cyc) begin
      chk("strobe_miss", 64'd0, sq[0].val);
      void'(sq.pop_front());
    end
    if (bus.frame_err) begin
      if (eq.size() == 0) chk("err_unexp", 64'd1, 64'd0);
      else begin
        e = eq.pop_front();
        chk("err_cyc", 64'(cyc), 64'(e.cyc));
      end
    end else if (eq.size() != 0 && eq[0].cyc <= cyc) begin
      chk("err_miss", 64'd0, 64'd1);
      void'(eq.pop_front());
    end
    if (bus.out_valid) begin
      prev_ov = last_ov;
      last_ov = cyc;
      if (fq.size() == 0) chk("ov_unexp", 64'(bus.out_data), 64'd0);
      else begin
        e = fq.pop_front();
        chk("ov_cyc", 64'(cyc), 64'(e.cyc));
        chk("out_data", 64'(bus.out_data), e.val);
      end
    end else if (fq.size() != 0 && fq[0].cyc <= cyc) begin
      chk("ov_miss", 64'd0, fq[0].val);
      void'(fq.pop_front());
    end
  end

  task automatic push_strobe(input int slot);
    exp_t e;
    e.cyc = cyc + 1; e.val = 64'(1) << slot;
    sq.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.cyc = cyc + 1; e.val = 64'd1;
    eq.push_back(e);
  endtask

  task automatic push_frame();
    exp_t e;
    e.cyc = cyc + 1; e.val = '0;
    for (int k = 0; k < NCH; k++) e.val[k*W +: W] = m_sh[k];
    fq.push_back(e);
  endtask

  // Drive one sample for one cycle and queue what the design should do with it.
  task automatic send(input logic [7:0] d, input bit sof);
    bus.in_valid = 1'b1; bus.in_sof = sof; bus.in_data = d;
    if (!m_coll) begin
      if (sof) begin m_sh[0] = d; push_strobe(0); m_cnt = 1; m_coll = 1'b1; end
    end else if (m_cnt == 0) begin
      if (sof) begin m_sh[0] = d; push_strobe(0); m_cnt = 1; end
      else begin push_err(); m_coll = 1'b0; end
    end else if (!sof) begin
      m_sh[m_cnt] = d; push_strobe(m_cnt);
      if (m_cnt == NCH-1) push_frame();
      m_cnt = (m_cnt + 1) % NCH;
    end else begin
      push_err(); m_sh[0] = d; push_strobe(0); m_cnt = 1;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_flags", {61'd0, bus.out_valid, bus.frame_err, |bus.ch_strobe}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_coll = 1'b0; m_cnt = 0;
    for (int k = 0; k < NCH; k++) m_sh[k] = '0;
  endtask

  task automatic frame(input logic [31:0] f);
    for (int k = 0; k < NCH; k++) send(f[k*8 +: 8], k == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data = '0;
    #1;
    do_reset();

    // 1: clean frame
    frame(32'h44332211);
    idle(1);
    chk("t1_data", 64'(bus.out_data), 64'h44332211);

    // 2: hunt from reset, non-SOF samples dropped silently
    do_reset();
    send(8'hAA, 0); send(8'hBB, 0);
    frame(32'h44332211);
    idle(1);
    chk("t2_data", 64'(bus.out_data), 64'h44332211);

    // 3: early SOF
    do_reset();
    send(8'h01, 1); send(8'h02, 0);
    frame(32'h40302010);
    idle(1);
    chk("t3_data", 64'(bus.out_data), 64'h40302010);

    // 4: missing SOF, then hunting stays silent, then recovery
    send(8'h55, 0);
    send(8'h66, 0);
    idle(1);
    chk("t4_hold", 64'(bus.out_data), 64'h40302010);
    frame(32'hD4C3B2A1);
    idle(1);
    chk("t4_recover", 64'(bus.out_data), 64'hD4C3B2A1);

    // 5a: gaps between samples
    send(8'h11, 1); idle(2); send(8'h22, 0); idle(1); send(8'h33, 0); idle(3); send(8'h44, 0);
    chk("t5_gap_data", 64'(bus.out_data), 64'h44332211);
    idle(1);

    // 5b: back-to-back frames
    frame(32'h04030201);
    frame(32'h08070605);
    idle(1);
    chk("t5_b2b_spacing", 64'(last_ov - prev_ov), 64'd4);
    chk("t5_b2b_data", 64'(bus.out_data), 64'h08070605);

    // 6: reset mid-frame
    send(8'hE1, 1); send(8'hE2, 0);
    do_reset();
    frame(32'h0D0C0B0A);
    idle(1);
    chk("t6_data", 64'(bus.out_data), 64'h0D0C0B0A);

    // random full-rate stream with occasional sof and gaps
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else send(8'($urandom), (i % NCH == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 15) == 0));
    end

    idle(4);
    chk("sq_drained", 64'(sq.size()), 64'd0);
    chk("eq_drained", 64'(eq.size()), 64'd0);
    chk("fq_drained", 64'(fq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Time-division demultiplexer: takes one sample stream in which channel 0 is marked by a start-of-frame flag, and steers each sample to its channel register.
- It is the receive/distribute end of a mux-based TDM link; the 1-to-N demux counterpart of the team's 2:1 mux primitives.
- Collects one full frame of NCH samples in shadow registers, then publishes the frame atomically with a one-cycle valid pulse.
- Detects framing errors and resynchronises on the next start-of-frame.

Parameters:
- NCH, 4, number of channels per frame (>= 2).
- W, 8, sample width in bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  sample present on in_data this cycle.
- in_sof  input  1  qualifies in_valid: this sample is channel 0.
- in_data  input  W  sample.
- out_data  output  NCH*W  published frame; channel k at bits [k*W +: W].
- out_valid  output  1  one-cycle pulse: out_data updated this cycle.
- ch_strobe  output  NCH  one-hot; bit k pulses the cycle after a sample is written to shadow slot k.
- frame_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. No input backpressure; every in_valid sample is consumed or dropped in its cycle.
- Reset:
  - state = HUNT, ch_cnt = 0.
  - shadow regs and out_data = 0.
  - out_valid, ch_strobe and frame_err = 0.
  - Reset mid-frame discards the partial frame; out_data clears.
- Channel counter: ch_cnt is $clog2(NCH) bits, range 0..NCH-1, wraps to 0 after the last channel.
- HUNT state:
  - in_valid && in_sof: write shadow[0], set ch_cnt = 1, go to COLLECT.
  - in_valid && !in_sof: sample dropped, no error pulse. Hunting is silent.
- COLLECT state, on in_valid:
  - ch_cnt == 0 && in_sof: write shadow[0], ch_cnt = 1. This is the normal next frame.
  - ch_cnt == 0 && !in_sof: frame_err pulses, sample dropped, go to HUNT.
  - ch_cnt != 0 && !in_sof: write shadow[ch_cnt], increment ch_cnt.
  - ch_cnt != 0 && in_sof: this is an early SOF. frame_err pulses, the partial frame is discarded (never published), the sample is written to shadow[0], ch_cnt = 1, and the state stays COLLECT.
- Frame publication:
  - When shadow[NCH-1] is written, out_data is loaded on the next edge with all NCH slots, including the one just written.
  - out_valid is high for exactly that cycle. Latency from the last sample to out_valid is 1 cycle.
  - out_data holds until the next publication or reset.
- ch_strobe: registered; exactly one bit high the cycle after each accepted write, zero otherwise. It is never set for dropped samples.
- in_valid low: no state change; all pulses deassert.
- Back-to-back frames at full rate (in_valid every cycle): out_valid pulses every NCH cycles with no bubble.
- Simultaneous events: a frame_err and an out_valid cannot occur in the same cycle, because an error discards the frame.

Decomposition:
- Package tdm_pkg holds:
  - the state enum {HUNT, COLLECT};
  - the function giving the counter width, clog2(NCH);
  - the default NCH/W localparams used by benches.
- One sub-module, demux_onehot:
  - combinational 1-to-NCH decoder (sel, en -> one-hot).
  - Drives the shadow write enables; its registered copy forms ch_strobe.

Test Plan (NCH=4, W=8):
1. Clean frame: in_valid every cycle, sof on 0x11, then 0x22, 0x33, 0x44 -> one cycle later out_valid=1 and out_data=0x44332211; ch_strobe shows 0001, 0010, 0100, 1000 on the cycles after each write.
2. Hunt: from reset send 0xAA, 0xBB without sof, then the frame from scenario 1 -> no frame_err, no strobes for 0xAA/0xBB, out_data=0x44332211.
3. Early SOF: sof 0x01, then 0x02, then sof 0x10, 0x20, 0x30, 0x40 -> frame_err pulses once at the second sof, then out_data=0x40302010 and no publication of 0x01/0x02.
4. Missing SOF: complete a frame, then a sample 0x55 without sof -> frame_err pulse, state HUNT, out_data keeps its previous frame. Next sof frame publishes normally.
5. Gaps and back-to-back:
   - Insert idle cycles between the samples of a frame -> published data is identical to the gap-free case, and out_valid comes 1 cycle after the last sample.
   - Send two frames with no gaps -> out_valid pulses 4 cycles apart.
6. Reset mid-frame: assert rst after 2 samples, release, send a full frame -> out_data reads 0 during reset, then holds only the new frame; no stale slots.
